// File: rtl/data_memory_pipelined_pkg.sv
// data_memory_pipelined_pkg: shared func3 codes, load-pipe stage records and byte-lane helpers
package data_memory_pipelined_pkg;
    localparam int ROB_TAG_W  = 5;
    localparam int PREG_TAG_W = 7;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef struct packed {
        logic                  valid;
        logic [ROB_TAG_W-1:0]  rob;
        logic [PREG_TAG_W-1:0] pd;
        logic [2:0]            func3;
        logic [1:0]            off;
        logic                  fault;
        logic [3:0]            fwd_be;
        logic [31:0]           fwd_data;
    } ld_stage_t;

    typedef struct packed {
        logic                  valid;
        logic [ROB_TAG_W-1:0]  rob;
        logic [PREG_TAG_W-1:0] pd;
        logic                  fault;
        logic [31:0]           data;
    } resp_stage_t;

    // zero enables mark an illegal store width
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        return f3 == F3_B ? 4'b0001 << off :
               f3 == F3_H ? (off[1] ? 4'b1100 : 4'b0011) :
               f3 == F3_W ? 4'b1111 : 4'b0000;
    endfunction

    function automatic logic [31:0] lane_data(input logic [2:0] f3, input logic [31:0] d);
        return f3 == F3_B ? {4{d[7:0]}} : f3 == F3_H ? {2{d[15:0]}} : d;
    endfunction
endpackage

// File: rtl/data_memory_pipelined_if.sv
// data_memory_pipelined_if: store-commit, load-issue, flush and response bundle between LSQ and data memory
interface data_memory_pipelined_if #(
    parameter int ROB_W  = data_memory_pipelined_pkg::ROB_TAG_W,
    parameter int PREG_W = data_memory_pipelined_pkg::PREG_TAG_W
);
    logic              st_valid;
    logic [31:0]       st_addr;
    logic [2:0]        st_func3;
    logic [31:0]       st_data;
    logic              ld_valid;
    logic [31:0]       ld_addr;
    logic [2:0]        ld_func3;
    logic [ROB_W-1:0]  ld_rob;
    logic [PREG_W-1:0] ld_pd;
    logic              flush;
    logic              resp_valid;
    logic [31:0]       resp_data;
    logic [ROB_W-1:0]  resp_rob;
    logic [PREG_W-1:0] resp_pd;
    logic              resp_fault;
    logic              st_err;

    modport master (
        output st_valid, st_addr, st_func3, st_data, ld_valid, ld_addr, ld_func3, ld_rob, ld_pd, flush,
        input  resp_valid, resp_data, resp_rob, resp_pd, resp_fault, st_err
    );
    modport slave (
        input  st_valid, st_addr, st_func3, st_data, ld_valid, ld_addr, ld_func3, ld_rob, ld_pd, flush,
        output resp_valid, resp_data, resp_rob, resp_pd, resp_fault, st_err
    );
endinterface

// File: rtl/data_memory_pipelined_mem_load_align.sv
// data_memory_pipelined_mem_load_align: selects and extends a byte/half/word from a 32-bit memory word
module data_memory_pipelined_mem_load_align
    import data_memory_pipelined_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  off,
    input  logic [2:0]  func3,
    output logic [31:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    assign b = word[{off, 3'b000} +: 8];
    assign h = off[1] ? word[31:16] : word[15:0];
    always_comb begin
        data = func3 == F3_B  ? {{24{b[7]}}, b} :
               func3 == F3_BU ? {24'h0, b} :
               func3 == F3_H  ? {{16{h[15]}}, h} :
               func3 == F3_HU ? {16'h0, h} : word;
    end
endmodule

// File: rtl/data_memory_pipelined.sv
// data_memory_pipelined: pipelined byte-enable BRAM with same-cycle store forwarding, load faults and flush
module data_memory_pipelined
    import data_memory_pipelined_pkg::*;
#(
    parameter int BYTE_DEPTH = 102400,
    parameter int LOAD_LAT   = 1
) (
    input logic clk,
    input logic reset,
    data_memory_pipelined_if.slave bus
);
    localparam int WDEPTH = (BYTE_DEPTH + 3) / 4;
    localparam int WADDR  = WDEPTH > 1 ? $clog2(WDEPTH) : 1;

    logic [31:0]      mem [WDEPTH];
    logic [WADDR-1:0] st_wa, ld_wa;
    logic [3:0]       st_be;
    logic [31:0]      st_lane, rd_word, be_mask, merged, ext;
    logic             st_ok, st_err_q, ld_fire, ld_bad;
    ld_stage_t        s1, s1_n;
    resp_stage_t      r1, out;

    assign st_wa   = bus.st_addr[WADDR+1:2];
    assign ld_wa   = bus.ld_addr[WADDR+1:2];
    assign st_be   = byte_en(bus.st_func3, bus.st_addr[1:0]);
    assign st_lane = lane_data(bus.st_func3, bus.st_data);
    assign st_ok   = bus.st_valid && st_be != 4'b0000 && bus.st_addr < 32'(BYTE_DEPTH) &&
                     !(bus.st_func3 == F3_H && bus.st_addr[0]) &&
                     !(bus.st_func3 == F3_W && bus.st_addr[1:0] != 2'b00);
    assign ld_fire = bus.ld_valid && !bus.flush;
    assign ld_bad  = bus.ld_addr >= 32'(BYTE_DEPTH) ||
                     bus.ld_func3 inside {3'b011, 3'b110, 3'b111} ||
                     ((bus.ld_func3 == F3_H || bus.ld_func3 == F3_HU) && bus.ld_addr[0]) ||
                     (bus.ld_func3 == F3_W && bus.ld_addr[1:0] != 2'b00);

    // the committing store is older than a same-cycle load, so its bytes override the read-first BRAM data
    assign s1_n = '{valid: 1'b1, rob: bus.ld_rob, pd: bus.ld_pd, func3: bus.ld_func3,
                    off: bus.ld_addr[1:0], fault: ld_bad,
                    fwd_be: (st_ok && st_wa == ld_wa) ? st_be : 4'b0000, fwd_data: st_lane};

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (st_ok && st_be[i]) mem[st_wa][8*i +: 8] <= st_lane[8*i +: 8];
        rd_word <= reset ? 32'h0 : ld_fire ? mem[ld_wa] : rd_word;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= '0;
            st_err_q <= 1'b0;
        end else begin
            st_err_q <= bus.st_valid && !st_ok;
            if (ld_fire) s1 <= s1_n;
            else s1.valid <= 1'b0;
        end
    end

    assign be_mask = {{8{s1.fwd_be[3]}}, {8{s1.fwd_be[2]}}, {8{s1.fwd_be[1]}}, {8{s1.fwd_be[0]}}};
    assign merged  = (rd_word & ~be_mask) | (s1.fwd_data & be_mask);

    data_memory_pipelined_mem_load_align u_align (
        .word  (merged),
        .off   (s1.off),
        .func3 (s1.func3),
        .data  (ext)
    );

    assign r1 = '{valid: s1.valid, rob: s1.rob, pd: s1.pd, fault: s1.fault, data: s1.fault ? 32'h0 : ext};

    generate
        if (LOAD_LAT == 1) begin : g_nodly
            assign out = r1;
        end else begin : g_dly
            resp_stage_t q [LOAD_LAT-1];
            resp_stage_t src [LOAD_LAT-1];
            always_comb begin
                src[0] = r1;
                for (int i = 1; i < LOAD_LAT - 1; i++) src[i] = q[i-1];
            end
            // payload only advances with a live load so idle outputs keep the last response
            always_ff @(posedge clk) begin
                for (int i = 0; i < LOAD_LAT - 1; i++)
                    if (reset) q[i] <= '0;
                    else if (src[i].valid && !bus.flush) q[i] <= src[i];
                    else q[i].valid <= 1'b0;
            end
            assign out = q[LOAD_LAT-2];
        end
    endgenerate

    assign bus.resp_valid = out.valid;
    assign bus.resp_fault = out.valid && out.fault;
    assign bus.resp_data  = out.data;
    assign bus.resp_rob   = out.rob;
    assign bus.resp_pd    = out.pd;
    assign bus.st_err     = st_err_q;
endmodule

// File: tb/tb_data_memory_pipelined.sv
// tb_data_memory_pipelined: table-driven store/load vectors with a response scoreboard plus flush and reset sequences
module tb_data_memory_pipelined;
    import data_memory_pipelined_pkg::*;
    localparam int LAT = 2;

    typedef struct {
        logic        sv;
        logic [31:0] sa;
        logic [2:0]  sf;
        logic [31:0] sd;
        logic        lv;
        logic [31:0] la;
        logic [2:0]  lf;
        logic [31:0] ed;
        logic        ef;
        logic        eerr;
    } vec_t;

    typedef struct {
        int          due;
        logic [4:0]  rob;
        logic [6:0]  pd;
        logic [31:0] data;
        logic        fault;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    data_memory_pipelined_if bus ();
    data_memory_pipelined #(.LOAD_LAT(LAT)) dut (.clk(clk), .reset(reset), .bus(bus));

    exp_t        sb [$];
    vec_t        tbl [24];
    vec_t        idle_v;
    int          n_cmp = 0, n_bad = 0, cyc = 0, n_resp = 0, r0;
    logic        exp_err = 1'b0, pend_err = 1'b0;
    logic [31:0] last_data = 32'h0;
    logic [4:0]  last_rob = 5'h0;
    logic [6:0]  last_pd = 7'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, req);
        end
    endtask

    task automatic check_resp();
        chk("st_err", 32'(bus.st_err), 32'(exp_err));
        if (bus.resp_valid) begin
            n_resp++;
            if (sb.size() == 0) chk("unexpected_resp_valid", 32'(bus.resp_valid), 32'h0);
            else begin
                exp_t e;
                e = sb.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                chk("resp_rob", 32'(bus.resp_rob), 32'(e.rob));
                chk("resp_pd", 32'(bus.resp_pd), 32'(e.pd));
                chk("resp_data", bus.resp_data, e.data);
                chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
                last_data = e.data;
                last_rob  = e.rob;
                last_pd   = e.pd;
            end
        end else begin
            chk("idle_fault", 32'(bus.resp_fault), 32'h0);
            chk("hold_data", bus.resp_data, last_data);
            chk("hold_rob", 32'(bus.resp_rob), 32'(last_rob));
            chk("hold_pd", 32'(bus.resp_pd), 32'(last_pd));
            if (sb.size() != 0 && sb[0].due <= cyc) begin
                chk("missing_resp", 32'(bus.resp_valid), 32'h1);
                void'(sb.pop_front());
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        exp_err  = pend_err;
        pend_err = 1'b0;
        @(negedge clk);
        check_resp();
    endtask

    task automatic drive(input vec_t v, input logic [4:0] rob, input logic [6:0] pd, input logic fl);
        bus.st_valid = v.sv;
        bus.st_addr  = v.sa;
        bus.st_func3 = v.sf;
        bus.st_data  = v.sd;
        bus.ld_valid = v.lv;
        bus.ld_addr  = v.la;
        bus.ld_func3 = v.lf;
        bus.ld_rob   = rob;
        bus.ld_pd    = pd;
        bus.flush    = fl;
        pend_err     = v.eerr;
        if (fl) sb.delete();
        if (v.lv && !fl) sb.push_back('{cyc + LAT, rob, pd, v.ed, v.ef});
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(idle_v, 5'h0, 7'h0, 1'b0);
    endtask

    task automatic check_reset_state();
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'h0);
        chk("rst_resp_data", bus.resp_data, 32'h0);
        chk("rst_resp_rob", 32'(bus.resp_rob), 32'h0);
        chk("rst_resp_pd", 32'(bus.resp_pd), 32'h0);
        chk("rst_resp_fault", 32'(bus.resp_fault), 32'h0);
        chk("rst_st_err", 32'(bus.st_err), 32'h0);
    endtask

    function automatic vec_t ld(input logic [31:0] a, input logic [2:0] f, input logic [31:0] d, input logic fault);
        return '{1'b0, 32'h0, 3'b000, 32'h0, 1'b1, a, f, d, fault, 1'b0};
    endfunction

    initial begin
        idle_v = '{1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0};
        tbl[0]  = '{1'b1, 32'h100, F3_W, 32'hDEADBEEF, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0};
        tbl[1]  = ld(32'h100, F3_W, 32'hDEADBEEF, 1'b0);
        tbl[2]  = ld(32'h103, F3_B, 32'hFFFFFFDE, 1'b0);
        tbl[3]  = ld(32'h103, F3_BU, 32'h000000DE, 1'b0);
        tbl[4]  = ld(32'h102, F3_H, 32'hFFFFDEAD, 1'b0);
        tbl[5]  = ld(32'h100, F3_HU, 32'h0000BEEF, 1'b0);
        tbl[6]  = '{1'b1, 32'h101, F3_B, 32'h00000055, 1'b1, 32'h100, F3_W, 32'hDEAD55EF, 1'b0, 1'b0};
        tbl[7]  = ld(32'h100, F3_W, 32'hDEAD55EF, 1'b0);
        tbl[8]  = ld(32'h102, F3_W, 32'h0, 1'b1);
        tbl[9]  = ld(32'h101, F3_H, 32'h0, 1'b1);
        tbl[10] = '{1'b1, 32'h104, F3_W, 32'h12345678, 1'b0, 32'h0, 3'b000, 32'h0, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'h106, F3_W, 32'hAAAAAAAA, 1'b1, 32'h104, F3_W, 32'h12345678, 1'b0, 1'b1};
        tbl[12] = ld(32'h104, F3_W, 32'h12345678, 1'b0);
        tbl[13] = '{1'b1, 32'h106, F3_H, 32'h0000CAFE, 1'b1, 32'h106, F3_HU, 32'h0000CAFE, 1'b0, 1'b0};
        tbl[14] = ld(32'h104, F3_W, 32'hCAFE5678, 1'b0);
        tbl[15] = '{1'b1, 32'h104, F3_B, 32'h00000080, 1'b1, 32'h104, F3_B, 32'hFFFFFF80, 1'b0, 1'b0};
        tbl[16] = '{1'b1, 32'h18FFC, F3_W, 32'h0BADF00D, 1'b1, 32'h19000, F3_W, 32'h0, 1'b1, 1'b0};
        tbl[17] = '{1'b1, 32'h19000, F3_W, 32'h11111111, 1'b1, 32'h18FFC, F3_W, 32'h0BADF00D, 1'b0, 1'b1};
        tbl[18] = '{1'b1, 32'h100, 3'b011, 32'h0, 1'b1, 32'h100, 3'b011, 32'h0, 1'b1, 1'b1};
        tbl[19] = ld(32'h100, F3_W, 32'hDEAD55EF, 1'b0);
        tbl[20] = ld(32'h104, F3_H, 32'h00005680, 1'b0);
        tbl[21] = ld(32'h106, F3_B, 32'hFFFFFFFE, 1'b0);
        tbl[22] = ld(32'h105, F3_HU, 32'h0, 1'b1);
        tbl[23] = '{1'b1, 32'h105, F3_H, 32'h0000FFFF, 1'b1, 32'h104, F3_W, 32'hCAFE5680, 1'b0, 1'b1};

        reset = 1'b1;
        bus.st_valid = 1'b0; bus.st_addr = 32'h0; bus.st_func3 = 3'b000; bus.st_data = 32'h0;
        bus.ld_valid = 1'b0; bus.ld_addr = 32'h0; bus.ld_func3 = 3'b000;
        bus.ld_rob = 5'h0; bus.ld_pd = 7'h0; bus.flush = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_state();

        for (int i = 0; i < 24; i++) drive(tbl[i], 5'(i + 1), 7'(i + 40), 1'b0);
        idle(LAT + 2);

        // four back-to-back loads; flush arrives with the fourth while the third sits in stage 1
        r0 = n_resp;
        drive(ld(32'h100, F3_W, 32'hDEAD55EF, 1'b0), 5'd1, 7'd1, 1'b0);
        drive(ld(32'h104, F3_W, 32'hCAFE5680, 1'b0), 5'd2, 7'd2, 1'b0);
        drive(ld(32'h100, F3_W, 32'hDEAD55EF, 1'b0), 5'd3, 7'd3, 1'b0);
        drive(ld(32'h104, F3_W, 32'hCAFE5680, 1'b0), 5'd4, 7'd4, 1'b1);
        idle(LAT + 3);
        chk("flush_resp_count", 32'(n_resp - r0), 32'd2);

        // reset while loads are in flight: nothing may respond, memory survives
        r0 = n_resp;
        drive(ld(32'h104, F3_W, 32'hCAFE5680, 1'b0), 5'd5, 7'd5, 1'b0);
        bus.ld_valid = 1'b1; bus.ld_addr = 32'h18FFC; bus.ld_func3 = F3_W; bus.ld_rob = 5'd6; bus.ld_pd = 7'd6;
        reset = 1'b1;
        sb.delete();
        last_data = 32'h0; last_rob = 5'h0; last_pd = 7'h0;
        tick();
        reset = 1'b0;
        check_reset_state();
        idle(LAT + 3);
        chk("reset_resp_count", 32'(n_resp - r0), 32'd0);
        drive(ld(32'h104, F3_W, 32'hCAFE5680, 1'b0), 5'd7, 7'd7, 1'b0);
        drive(ld(32'h18FFC, F3_W, 32'h0BADF00D, 1'b0), 5'd8, 7'd8, 1'b0);
        drive(ld(32'h100, F3_W, 32'hDEAD55EF, 1'b0), 5'd9, 7'd9, 1'b0);
        idle(LAT + 2);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
